// File: rtl/regfile_writeback_unit.sv
// Write-side initiator for the 4x16 register file: zero-fills every register after reset,
// then merges ALU and load writebacks through a small FIFO into one write per clock.
module regfile_writeback_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 2,
  parameter int NUM_REGS   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          Clock,
  input  logic                          Reset_n,
  input  logic                          AluValid,
  input  logic [ADDR_WIDTH-1:0]         AluRD,
  input  logic [DATA_WIDTH-1:0]         AluData,
  output logic                          AluReady,
  input  logic                          MemValid,
  input  logic [ADDR_WIDTH-1:0]         MemRD,
  input  logic [DATA_WIDTH-1:0]         MemData,
  output logic                          MemReady,
  output logic [ADDR_WIDTH-1:0]         RD,
  output logic [DATA_WIDTH-1:0]         WriteData,
  output logic                          RegWrite,
  output logic                          Busy,
  output logic [$clog2(FIFO_DEPTH):0]   Pending
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {S_CLEAR, S_RUN} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q;
  logic [CW-1:0]           count_q, count_d;
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q, alu_slot;
  logic [ADDR_WIDTH-1:0]   fifo_rd_q   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   fifo_data_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]   rd_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    regwrite_q, busy_q;
  logic [CW-1:0]           free;
  logic                    run, mem_push, alu_push, pop;

  // Room is judged on the count before this edge's pop, so a same-cycle pop never
  // makes space; when only one slot is free it goes to the (older) load.
  always_comb begin
    run      = (state_q == S_RUN);
    free     = CW'(FIFO_DEPTH) - count_q;
    MemReady = run && (free >= CW'(1));
    AluReady = run && ((free >= CW'(2)) || ((free == CW'(1)) && !MemValid));
    mem_push = MemValid && MemReady;
    alu_push = AluValid && AluReady;
    pop      = run && (count_q != '0);
    alu_slot = wr_ptr_q + PW'(mem_push);
    count_d  = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q    <= S_CLEAR;
      clr_cnt_q  <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_q       <= '0;
      wdata_q    <= '0;
      regwrite_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      case (state_q)
        S_CLEAR: begin
          regwrite_q <= 1'b1;
          rd_q       <= clr_cnt_q;
          wdata_q    <= '0;
          clr_cnt_q  <= clr_cnt_q + ADDR_WIDTH'(1);
          if (clr_cnt_q == ADDR_WIDTH'(NUM_REGS - 1)) begin
            state_q <= S_RUN;
            busy_q  <= 1'b0;
          end
        end
        S_RUN: begin
          if (mem_push) begin
            fifo_rd_q[wr_ptr_q]   <= MemRD;
            fifo_data_q[wr_ptr_q] <= MemData;
          end
          if (alu_push) begin
            fifo_rd_q[alu_slot]   <= AluRD;
            fifo_data_q[alu_slot] <= AluData;
          end
          wr_ptr_q <= wr_ptr_q + PW'(mem_push) + PW'(alu_push);
          if (pop) begin
            rd_q       <= fifo_rd_q[rd_ptr_q];
            wdata_q    <= fifo_data_q[rd_ptr_q];
            rd_ptr_q   <= rd_ptr_q + PW'(1);
            regwrite_q <= 1'b1;
          end else begin
            regwrite_q <= 1'b0;
          end
          count_q <= count_d;
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  assign RD        = rd_q;
  assign WriteData = wdata_q;
  assign RegWrite  = regwrite_q;
  assign Busy      = busy_q;
  assign Pending   = count_q;

endmodule

// File: tb/tb_regfile_writeback_unit.sv
// Bench for regfile_writeback_unit: fixed vector table, directed corner sequences and
// random traffic, all checked against a queue-based reference model.
module tb_regfile_writeback_unit;

  logic        Clock = 1'b0;
  logic        Reset_n, AluValid, MemValid;
  logic [1:0]  AluRD, MemRD, RD;
  logic [15:0] AluData, MemData, WriteData;
  logic        AluReady, MemReady, RegWrite, Busy;
  logic [2:0]  Pending;

  regfile_writeback_unit #(
    .DATA_WIDTH(16), .ADDR_WIDTH(2), .NUM_REGS(4), .FIFO_DEPTH(4)
  ) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .AluValid(AluValid), .AluRD(AluRD), .AluData(AluData), .AluReady(AluReady),
    .MemValid(MemValid), .MemRD(MemRD), .MemData(MemData), .MemReady(MemReady),
    .RD(RD), .WriteData(WriteData), .RegWrite(RegWrite), .Busy(Busy), .Pending(Pending)
  );

  always #5 Clock = ~Clock;

  int unsigned n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of pending writes plus the clear progress.
  typedef struct packed { logic [1:0] rd; logic [15:0] d; } ent_t;
  ent_t        mq[$];
  int unsigned m_clr = 0;
  bit          m_run = 0, m_valid = 0;
  logic        m_rw;
  logic [1:0]  m_rd;
  logic [15:0] m_wd;
  logic [15:0] rf_obs [4];

  function automatic bit m_mready();
    return m_run && (4 - mq.size() >= 1);
  endfunction

  function automatic bit m_aready();
    int free;
    free = 4 - mq.size();
    return m_run && ((free >= 2) || (free == 1 && !MemValid));
  endfunction

  task automatic drive(input int r, input int av, input int ard, input int ad,
                       input int mv, input int mrd, input int md);
    Reset_n  = r[0];
    AluValid = av[0]; AluRD = ard[1:0]; AluData = ad[15:0];
    MemValid = mv[0]; MemRD = mrd[1:0]; MemData = md[15:0];
    #2;
    if (m_valid) begin
      chk("alu_ready", AluReady, m_aready());
      chk("mem_ready", MemReady, m_mready());
    end
  endtask

  task automatic tick();
    bit   ar, mr;
    ent_t e;
    ar = m_aready();
    mr = m_mready();
    if (!Reset_n) begin
      mq.delete(); m_clr = 0; m_run = 0; m_rw = 0; m_rd = '0; m_wd = '0; m_valid = 1;
    end else if (m_valid) begin
      if (!m_run) begin
        m_rw = 1; m_rd = m_clr[1:0]; m_wd = '0; m_clr++;
        if (m_clr == 4) m_run = 1;
      end else begin
        if (mq.size() > 0) begin
          e = mq.pop_front(); m_rw = 1; m_rd = e.rd; m_wd = e.d;
        end else begin
          m_rw = 0;
        end
        if (MemValid && mr) mq.push_back({MemRD, MemData});
        if (AluValid && ar) mq.push_back({AluRD, AluData});
      end
    end
    @(posedge Clock);
    #1;
    if (m_valid) begin
      chk("regwrite", RegWrite, m_rw);
      chk("rd", RD, m_rd);
      chk("wdata", WriteData, m_wd);
      chk("busy", Busy, !m_run);
      chk("pending", Pending, mq.size());
    end
    if (RegWrite === 1'b1) rf_obs[RD] = WriteData;
  endtask

  typedef struct {
    logic rst, av; logic [1:0] ard; logic [15:0] ad;
    logic mv;      logic [1:0] mrd; logic [15:0] md;
    logic ck, e_ar, e_mr, e_rw; logic [1:0] e_rd; logic [15:0] e_wd;
    logic e_busy;  logic [2:0] e_pend;
  } vec_t;

  function automatic vec_t mk(input int r, av, ard, ad, mv, mrd, md,
                              ck, ar, mr, rw, rd, wd, bs, pd);
    vec_t v;
    v.rst = r[0]; v.av = av[0]; v.ard = ard[1:0]; v.ad = ad[15:0];
    v.mv = mv[0]; v.mrd = mrd[1:0]; v.md = md[15:0];
    v.ck = ck[0]; v.e_ar = ar[0]; v.e_mr = mr[0]; v.e_rw = rw[0];
    v.e_rd = rd[1:0]; v.e_wd = wd[15:0]; v.e_busy = bs[0]; v.e_pend = pd[2:0];
    return v;
  endfunction

  vec_t tbl[14];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   prev_pend;
    logic [15:0] d;
    //            rst av rd  ad     mv rd  md      ck ar mr  rw rd wd  bs pd
    tbl[0]  = mk(0, 0, 0, 0,     0, 0, 0,      0, 0, 0,  0, 0, 0,  1, 0);
    tbl[1]  = mk(0, 0, 0, 0,     1, 1, 'h33,   1, 0, 0,  0, 0, 0,  1, 0);
    tbl[2]  = mk(1, 0, 0, 0,     0, 0, 0,      1, 0, 0,  1, 0, 0,  1, 0);
    tbl[3]  = mk(1, 0, 0, 0,     1, 2, 'h44,   1, 0, 0,  1, 1, 0,  1, 0);
    tbl[4]  = mk(1, 1, 1, 'h11,  0, 0, 0,      1, 0, 0,  1, 2, 0,  1, 0);
    tbl[5]  = mk(1, 0, 0, 0,     0, 0, 0,      1, 0, 0,  1, 3, 0,  0, 0);
    tbl[6]  = mk(1, 0, 0, 0,     0, 0, 0,      1, 1, 1,  0, 3, 0,  0, 0);
    tbl[7]  = mk(1, 1, 3, 5,     0, 0, 0,      1, 1, 1,  0, 3, 0,  0, 1);
    tbl[8]  = mk(1, 0, 0, 0,     0, 0, 0,      1, 1, 1,  1, 3, 5,  0, 0);
    tbl[9]  = mk(1, 0, 0, 0,     0, 0, 0,      1, 1, 1,  0, 3, 5,  0, 0);
    tbl[10] = mk(1, 1, 2, 9,     1, 2, 7,      1, 1, 1,  0, 3, 5,  0, 2);
    tbl[11] = mk(1, 0, 0, 0,     0, 0, 0,      1, 1, 1,  1, 2, 7,  0, 1);
    tbl[12] = mk(1, 0, 0, 0,     0, 0, 0,      1, 1, 1,  1, 2, 9,  0, 0);
    tbl[13] = mk(1, 0, 0, 0,     0, 0, 0,      1, 1, 1,  0, 2, 9,  0, 0);

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rst, tbl[i].av, tbl[i].ard, tbl[i].ad, tbl[i].mv, tbl[i].mrd, tbl[i].md);
      if (tbl[i].ck) begin
        chk($sformatf("tbl%0d_alu_ready", i), AluReady, tbl[i].e_ar);
        chk($sformatf("tbl%0d_mem_ready", i), MemReady, tbl[i].e_mr);
      end
      tick();
      chk($sformatf("tbl%0d_regwrite", i), RegWrite, tbl[i].e_rw);
      chk($sformatf("tbl%0d_rd", i), RD, tbl[i].e_rd);
      chk($sformatf("tbl%0d_wdata", i), WriteData, tbl[i].e_wd);
      chk($sformatf("tbl%0d_busy", i), Busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_pending", i), Pending, tbl[i].e_pend);
    end
    chk("r2_last_wins", rf_obs[2], 16'h0009);

    // Both sources held: the queue saturates but never overflows.
    for (int i = 0; i < 12; i++) begin
      drive(1, 1, i % 4, 'h100 + i, 1, (i + 1) % 4, 'h200 + i);
      if (mq.size() == 3) chk("alu_blocked_cnt3", AluReady, 0);
      tick();
      chk("pending_le4", Pending <= 3'd4, 1);
    end

    // Reset with entries queued: they are dropped and the clear sequence repeats.
    drive(1, 0, 0, 0, 0, 0, 0);
    while (mq.size() < 3) begin
      drive(1, 1, 1, 'hDEAD, 1, 1, 'hBEEF);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("rst_mid_regwrite", RegWrite, 0);
    chk("rst_mid_pending", Pending, 0);
    chk("rst_mid_busy", Busy, 1);
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 0, 0, 0, 0, 0);
      tick();
      chk($sformatf("reclear%0d_rd", k), RD, k);
      chk($sformatf("reclear%0d_rw", k), RegWrite, 1);
      chk($sformatf("reclear%0d_wd", k), WriteData, 0);
    end

    // Alternating burst: every pending entry is written on the very next edge.
    prev_pend = 0;
    for (int i = 0; i < 10; i++) begin
      d = 16'hA000 + 16'(i);
      if (i >= 8)          drive(1, 0, 0, 0, 0, 0, 0);
      else if (i % 2 == 0) drive(1, 1, i % 4, d, 0, 0, 0);
      else                 drive(1, 0, 0, 0, 1, i % 4, d);
      tick();
      if (prev_pend > 0) chk("burst_no_idle", RegWrite, 1);
      prev_pend = int'(Pending);
    end

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 60) != 0) ? 1 : 0, $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 65535), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 65535));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
